// File: rtl/posit_cmp_arbiter.sv
// posit_cmp_arbiter: two requesters share one posit magnitude comparator; result held in a one-entry response buffer.
// Round-robin arbitration when POSIT_CMP_ARB_RR_EN is defined, fixed priority to requester 0 otherwise.
module posit_comparator #(
  parameter int W_REG = 8,
  parameter int W_EXP = 2,
  parameter int W_MAN = 16,
  localparam int W_P = 1 + W_REG + W_EXP + W_MAN
) (
  input  logic [W_P-1:0] a,
  input  logic [W_P-1:0] b,
  output logic           a_big
);
  logic signed [W_REG-1:0] ra, rb;
  logic signed [W_EXP-1:0] ea, eb;
  logic [W_MAN-1:0] ma, mb;
  assign ra = a[W_P-2 -: W_REG];
  assign rb = b[W_P-2 -: W_REG];
  assign ea = a[W_MAN +: W_EXP];
  assign eb = b[W_MAN +: W_EXP];
  assign ma = a[W_MAN-1:0];
  assign mb = b[W_MAN-1:0];
  assign a_big = (ra != rb) ? (ra > rb) : (ea != eb) ? (ea > eb) : (ma > mb);
endmodule

module posit_cmp_arbiter #(
  parameter int W_REG = 8,
  parameter int W_EXP = 2,
  parameter int W_MAN = 16,
  localparam int W_P = 1 + W_REG + W_EXP + W_MAN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W_P-1:0] req0_a,
  input  logic [W_P-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W_P-1:0] req1_a,
  input  logic [W_P-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W_P-1:0] rsp_big,
  output logic [W_P-1:0] rsp_small,
  output logic           rsp_a_big
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;
  logic prio, g1, can_accept, accept, a_big;
  logic [W_P-1:0] sel_a, sel_b;
`ifdef POSIT_CMP_ARB_RR_EN
  always_ff @(posedge clk)
    if (rst) prio <= 1'b0;
    else if (accept) prio <= ~g1;
`else
  assign prio = 1'b0;
`endif
  // rst gates ready so nothing is accepted while the buffer is being cleared
  assign g1 = req1_valid & (~req0_valid | prio);
  assign can_accept = ~rst & ((state == EMPTY) | rsp_ready);
  assign req0_ready = can_accept & req0_valid & ~g1;
  assign req1_ready = can_accept & g1;
  assign accept = req0_ready | req1_ready;
  assign sel_a = g1 ? req1_a : req0_a;
  assign sel_b = g1 ? req1_b : req0_b;
  posit_comparator #(.W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN)) comparator (
    .a(sel_a), .b(sel_b), .a_big(a_big)
  );
  always_comb state_next = accept ? FULL : rsp_ready ? EMPTY : state;
  always_ff @(posedge clk)
    if (rst) state <= EMPTY;
    else state <= state_next;
  always_ff @(posedge clk)
    if (rst) begin
      rsp_id <= 1'b0;
      rsp_big <= '0;
      rsp_small <= '0;
      rsp_a_big <= 1'b0;
    end else if (accept) begin
      rsp_id <= g1;
      rsp_big <= a_big ? sel_a : sel_b;
      rsp_small <= a_big ? sel_b : sel_a;
      rsp_a_big <= a_big;
    end
  assign rsp_valid = (state == FULL);
endmodule

// File: tb/tb_posit_cmp_arbiter.sv
// tb_posit_cmp_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_posit_cmp_arbiter;
  localparam int W_P = 27;
`ifdef POSIT_CMP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [W_P-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_a_big;
  logic [W_P-1:0] rsp_big, rsp_small;
  int checks = 0, failures = 0;

  posit_cmp_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_big(rsp_big), .rsp_small(rsp_small), .rsp_a_big(rsp_a_big)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // magnitude as a single integer: regime dominates exponent dominates mantissa
  function automatic longint mag(input logic [W_P-1:0] x);
    longint r, e;
    r = longint'($signed(x[25:18]));
    e = longint'($signed(x[17:16]));
    return (r * 4 + e) * 65536 + longint'(x[15:0]);
  endfunction

  logic m_full = 0, m_prio = 0, m_id = 0, m_abig = 0;
  logic [W_P-1:0] m_big = '0, m_small = '0;

  function automatic logic winner();
    if (req0_valid && req1_valid) return RR ? m_prio : 1'b0;
    return req1_valid;
  endfunction

  always @(posedge clk) begin
    logic w, acc;
    logic [W_P-1:0] a, b;
    w = winner();
    acc = (req0_valid | req1_valid) & (~m_full | rsp_ready);
    a = w ? req1_a : req0_a;
    b = w ? req1_b : req0_b;
    if (rst) begin
      m_full <= 0; m_prio <= 0; m_id <= 0; m_abig <= 0; m_big <= '0; m_small <= '0;
    end else if (acc) begin
      m_full <= 1;
      m_id <= w;
      m_abig <= mag(a) > mag(b);
      m_big <= mag(a) > mag(b) ? a : b;
      m_small <= mag(a) > mag(b) ? b : a;
      if (RR) m_prio <= ~w;
    end else if (rsp_ready) m_full <= 0;
  end

  always @(negedge clk) begin
    logic w, can;
    w = winner();
    can = ~rst & (~m_full | rsp_ready);
    check("req0_ready", 32'(req0_ready), 32'(can & req0_valid & ~w));
    check("req1_ready", 32'(req1_ready), 32'(can & req1_valid & w));
    check("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_big", 32'(rsp_big), 32'(m_big));
    check("rsp_small", 32'(rsp_small), 32'(m_small));
    check("rsp_a_big", 32'(rsp_a_big), 32'(m_abig));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W_P-1:0] t1a = {1'b0, 8'sd1, 2'sd0, 16'h0000};
  logic [W_P-1:0] t1b = {1'b1, 8'sd0, 2'sd1, 16'hFFFF};
  logic [W_P-1:0] eqb = {1'b0, 8'sd2, 2'sd1, 16'h1234};
  logic [W_P-1:0] eqa = {1'b1, 8'sd2, 2'sd1, 16'h1234};
  logic [W_P-1:0] held;
  logic [3:0] ids;

  initial begin
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_big", 32'(rsp_big), 0);
    step();
    rst = 0;
    req0_valid = 1; req0_a = t1a; req0_b = t1b; rsp_ready = 1;
    step();
    req0_valid = 0;
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_id", 32'(rsp_id), 0);
    check("t1_big", 32'(rsp_big), 32'(t1a));
    check("t1_small", 32'(rsp_small), 32'(t1b));
    check("t1_a_big", 32'(rsp_a_big), 1);
    req1_valid = 1; req1_a = eqa; req1_b = eqb;
    step();
    req1_valid = 0;
    check("eq_id", 32'(rsp_id), 1);
    check("eq_a_big", 32'(rsp_a_big), 0);
    check("eq_big", 32'(rsp_big), 32'(eqb));
    check("eq_small", 32'(rsp_small), 32'(eqa));
    req0_valid = 1; req1_valid = 1;
    req0_a = t1b; req0_b = t1a; req1_a = t1a; req1_b = eqb;
    for (int i = 0; i < 4; i++) begin
      step();
      ids[i] = rsp_id;
    end
    check("rr_seq", 32'(ids), RR ? 32'b1010 : 32'b0000);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    held = rsp_big;
    req1_valid = 1; req1_a = eqb; req1_b = t1b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req1_ready", 32'(req1_ready), 0);
      check("bp_hold_big", 32'(rsp_big), 32'(held));
      step();
    end
    rsp_ready = 1;
    @(negedge clk);
    check("bp_release_ready", 32'(req1_ready), 1);
    step();
    req1_valid = 0;
    check("bp_new_valid", 32'(rsp_valid), 1);
    check("bp_new_id", 32'(rsp_id), 1);
    check("bp_new_big", 32'(rsp_big), 32'(eqb));
    req0_valid = 1; req0_a = t1a; req0_b = t1b; rsp_ready = 0;
    step();
    req0_valid = 0;
    rst = 1;
    step();
    rst = 0;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_big", 32'(rsp_big), 0);
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    @(negedge clk);
    check("rst_grant0", 32'(req0_ready), 1);
    check("rst_grant1", 32'(req1_ready), 0);
    for (int i = 0; i < 400; i++) begin
      step();
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 2) != 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      req0_a = W_P'($urandom); req0_b = W_P'($urandom);
      req1_a = W_P'($urandom); req1_b = W_P'($urandom);
      if ($urandom_range(0, 3) == 0) req0_b = {~req0_a[26], req0_a[25:0]};
      if ($urandom_range(0, 3) == 0) req1_b[25:16] = req1_a[25:16];
      if (i == 200) rst = 1;
      if (i == 201) rst = 0;
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_cmp_arbiter.md
# posit_cmp_arbiter

Shares one posit magnitude `comparator` instance between two requesters. Each requester hands over a pair of decoded posit operands. The block registers the comparator's big/small split and returns it with the requester's ID over a single-entry buffered response channel. It sits between the decode stage and the add/sub alignment stage, which both need big/small ordering, so only one comparator is instantiated per ALU.

## Interface
Parameters:
- `W_REG`, 8, regime field width (signed)
- `W_EXP`, 2, exponent field width (signed)
- `W_MAN`, 16, mantissa field width (unsigned)
- `W_P` (localparam), `1+W_REG+W_EXP+W_MAN`, packed operand width; field order MSB→LSB {sign, regime, exponent, mantissa}

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req0_valid` in 1: requester 0 presents an operand pair
- `req0_ready` out 1: requester 0 pair accepted this cycle when high with valid
- `req0_a`, `req0_b` in `W_P`: requester 0 operands
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1
- `rsp_valid` out 1: result held in output register
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out 1: index of the requester that owns the result
- `rsp_big` out `W_P`: operand with larger magnitude
- `rsp_small` out `W_P`: the other operand
- `rsp_a_big` out 1: 1 when operand a was selected as big

## Operation
- Ordering is computed by the shared comparator.
  - a is big iff regime(a)>regime(b) (signed); else on equal regime, exponent(a)>exponent(b) (signed); else on equal exponent, mantissa(a)>mantissa(b) (unsigned).
  - Sign is not compared. It travels with its operand.
  - On full equality, b is big and a is small (`rsp_a_big`=0).
- The output buffer has two states.
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY→FULL on any accepted request.
  - FULL→EMPTY on `rsp_ready` with no new accept.
  - FULL→FULL on `rsp_ready` with a simultaneous accept; the buffer is reloaded with the new result.
- `can_accept` = EMPTY | `rsp_ready`.
  - `reqN_ready` = `can_accept` & grant(N).
  - At most one `reqN_ready` is high per cycle.
- Grant is decided combinationally from the current valids and the priority pointer `prio`.
  - If only one requester is valid, it wins.
  - If both are valid, requester `prio` wins.
  - `reqN_ready` is asserted only when `reqN_valid` is high.
  - `ready` never depends on `rsp_valid` of the same requester.
- `prio` flips to the non-winner only on an accepted handshake. It is unchanged on stall or idle.
- While FULL and `rsp_ready`=0, all `rsp_*` outputs hold stable.
- Requesters may drop `valid` without handshake. The arbiter carries no state about unaccepted requests.

## Timing
- Latency: request accepted at edge N gives `rsp_valid` high from edge N+1 with the result.
- Throughput: one result per cycle with continuous `rsp_ready`=1. Two valid requesters alternate every cycle.
- No combinational path from `reqN_a/b` to `rsp_*`. `rsp_ready` → `reqN_ready` is combinational.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_big`=0, `rsp_small`=0, `rsp_a_big`=0, `prio`=0, `req0_ready`=`req1_ready`=0 while `rst`=1.
- Reset mid-operation: a held result is discarded with no handshake. The first cycle after `rst` deasserts may accept a request.

## Configuration
- `POSIT_CMP_ARB_RR_EN` defined: round-robin via `prio` as above.
- `POSIT_CMP_ARB_RR_EN` undefined:
  - Fixed priority; requester 0 always wins when both are valid.
  - `prio` register is removed.
  - Requester 1 may starve under continuous requester-0 traffic. This is permitted.

## Test plan
- Single request, defaults: `req0_a`={0, 8'sd1, 2'sd0, 16'h0000}, `req0_b`={1, 8'sd0, 2'sd1, 16'hFFFF}, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_big`=`req0_a`, `rsp_a_big`=1.
- Equal operands a=b={0, 8'sd2, 2'sd1, 16'h1234}, but a with sign 1 → `rsp_a_big`=0, `rsp_big`=b, `rsp_small`=a (sign ignored, tie goes to b).
- Both valid for 4 cycles, `rsp_ready`=1, RR_EN defined → `rsp_id` sequence 0,1,0,1. With RR_EN undefined → 0,0,0,0 and `req1_ready` never high.
- Backpressure: fill buffer, hold `rsp_ready`=0 for 3 cycles with `req1_valid`=1 → both readys 0, `rsp_*` stable. Raise `rsp_ready` → same-cycle `req1_ready`=1, new result next cycle, no bubble.
- Mid-operation reset: buffer FULL, assert `rst` 1 cycle → `rsp_valid`=0 next cycle, `prio`=0. A subsequent both-valid request grants requester 0.
